// File: rtl/keypad_matrix_scan.sv
// 4x4 keypad scanner: rotates active-low row drives, synchronises and debounces
// the column frame, and emits a one-cycle one-hot key pulse with chord rejection.
module keypad_matrix_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        V1,
    input  logic        V2,
    input  logic        V3,
    input  logic        V4,
    output logic        H1,
    output logic        H2,
    output logic        H3,
    output logic        H4,
    output logic [15:0] res,
    output logic        pressed,
    output logic        chord
);

    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS,
        S_BLOCK
    } state_t;

    logic [3:0]    v_meta;
    logic [3:0]    v_sync;
    logic [3:0]    h_drive;
    logic [1:0]    row;
    logic [DW-1:0] dwell;
    logic [15:0]   raw;
    logic [15:0]   prev;
    logic [15:0]   debounced;
    logic [15:0]   held_key;
    logic [3:0]    stable;
    logic          frame_done;
    logic          deb_valid;
    logic          one_hot;
    state_t        state;
    state_t        next_state;

    assign {H4, H3, H2, H1} = h_drive;

    // Row scan: columns are captured on the last dwell cycle so the
    // synchroniser has fully settled on the currently driven row.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            v_meta     <= '0;
            v_sync     <= '0;
            h_drive    <= 4'b1110;
            row        <= '0;
            dwell      <= '0;
            raw        <= '0;
            frame_done <= 1'b0;
        end else begin
            v_meta     <= {V4, V3, V2, V1};
            v_sync     <= v_meta;
            frame_done <= 1'b0;
            if (dwell == DW'(SCAN_DIV - 1)) begin
                dwell                  <= '0;
                raw[{row, 2'b00} +: 4] <= ~v_sync;
                row                    <= row + 2'd1;
                h_drive                <= {h_drive[2:0], h_drive[3]};
                frame_done             <= (row == 2'd3);
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

    // Frame debouncer: the accepted frame updates only on the transition
    // into saturation, so a long hold produces a single update.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev      <= '0;
            stable    <= '0;
            debounced <= '0;
            deb_valid <= 1'b0;
        end else begin
            deb_valid <= 1'b0;
            if (frame_done) begin
                if (raw == prev) begin
                    if (stable < 4'(DEBOUNCE_CNT)) begin
                        stable <= stable + 4'd1;
                        if (stable + 4'd1 == 4'(DEBOUNCE_CNT)) begin
                            debounced <= prev;
                            deb_valid <= 1'b1;
                        end
                    end
                end else begin
                    stable <= '0;
                    prev   <= raw;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            held_key <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && next_state == S_PRESS) begin
                held_key <= debounced;
            end
        end
    end

    // Key FSM: a chord blocks all output until a full release is accepted.
    always_comb begin
        next_state = state;
        res        = '0;
        one_hot    = (debounced != '0) && ((debounced & (debounced - 16'd1)) == '0);
        if (deb_valid) begin
            case (state)
                S_IDLE: begin
                    if (one_hot) begin
                        res        = debounced;
                        next_state = S_PRESS;
                    end else if (debounced != '0) begin
                        next_state = S_BLOCK;
                    end
                end
                S_PRESS: begin
                    if (debounced == '0) begin
                        next_state = S_IDLE;
                    end else if (debounced != held_key) begin
                        next_state = S_BLOCK;
                    end
                end
                S_BLOCK: begin
                    if (debounced == '0) begin
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
        pressed = (state == S_PRESS);
        chord   = (state == S_BLOCK);
    end

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Directed bench for keypad_matrix_scan with a behavioural 4x4 key matrix
// and immediate-assertion checks against hand-computed expectations.
module tb_keypad_matrix_scan;

    logic        CLK;
    logic        RESET;
    logic        V1, V2, V3, V4;
    logic        H1, H2, H3, H4;
    logic [15:0] res;
    logic        pressed;
    logic        chord;

    logic [15:0] keys;
    logic [3:0]  v_cols;
    logic [3:0]  h;
    logic [3:0]  exp_h;
    logic [15:0] prev_res;
    logic [15:0] last_res;
    int          checks;
    int          errors;
    int          pulse_total;
    int          wide_total;
    int          bad_onehot;
    int          res_in_chord;
    int          snap;

    keypad_matrix_scan #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(2)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .V1(V1),
        .V2(V2),
        .V3(V3),
        .V4(V4),
        .H1(H1),
        .H2(H2),
        .H3(H3),
        .H4(H4),
        .res(res),
        .pressed(pressed),
        .chord(chord)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign h = {H4, H3, H2, H1};
    assign {V4, V3, V2, V1} = v_cols;

    // A held key pulls its column low only while its row is driven low.
    always_comb begin
        v_cols = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!h[r] && keys[r*4+c]) begin
                    v_cols[c] = 1'b0;
                end
            end
        end
    end

    initial begin
        pulse_total  = 0;
        wide_total   = 0;
        bad_onehot   = 0;
        res_in_chord = 0;
        prev_res     = '0;
        last_res     = '0;
    end

    always @(negedge CLK) begin
        if (res !== 16'h0000) begin
            pulse_total++;
            last_res = res;
            if ($countones(res) != 1) bad_onehot++;
            if (prev_res !== 16'h0000) wide_total++;
            if (chord) res_in_chord++;
        end
        prev_res = res;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int frames);
        keys = k;
        repeat (frames * 16) @(negedge CLK);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        keys   = '0;
        RESET  = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        checkOutput("reset_h", 32'(h), 32'h0000_000e);
        checkOutput("reset_res", 32'(res), 32'h0);
        checkOutput("reset_pressed", 32'(pressed), 32'h0);
        checkOutput("reset_chord", 32'(chord), 32'h0);

        $display("[TB] idle scan");
        snap  = pulse_total;
        exp_h = 4'b1110;
        for (int i = 0; i < 40; i++) begin
            checkOutput("h_rotation", 32'(h), 32'(exp_h));
            exp_h = {exp_h[2:0], exp_h[3]};
            repeat (4) @(negedge CLK);
        end
        checkOutput("idle_pulses", 32'(pulse_total - snap), 32'h0);
        checkOutput("idle_pressed", 32'(pressed), 32'h0);
        checkOutput("idle_chord", 32'(chord), 32'h0);

        $display("[TB] single key row2/col1");
        snap = pulse_total;
        applyStimulus(16'h0200, 5);
        checkOutput("key0200_pulses", 32'(pulse_total - snap), 32'h1);
        checkOutput("key0200_value", 32'(last_res), 32'h0000_0200);
        checkOutput("key0200_pressed", 32'(pressed), 32'h1);
        applyStimulus(16'h0000, 5);
        checkOutput("key0200_release", 32'(pressed), 32'h0);
        checkOutput("key0200_total", 32'(pulse_total - snap), 32'h1);

        $display("[TB] bounce then hold");
        snap = pulse_total;
        for (int i = 0; i < 13; i++) begin
            keys = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            repeat (6) @(negedge CLK);
        end
        checkOutput("bounce_pulses", 32'(pulse_total - snap), 32'h0);
        applyStimulus(16'h0200, 5);
        checkOutput("bounce_hold_pulses", 32'(pulse_total - snap), 32'h1);
        checkOutput("bounce_hold_value", 32'(last_res), 32'h0000_0200);
        applyStimulus(16'h0000, 5);
        checkOutput("bounce_release", 32'(pressed), 32'h0);

        $display("[TB] chord");
        snap = pulse_total;
        applyStimulus(16'h8001, 5);
        checkOutput("chord_level", 32'(chord), 32'h1);
        checkOutput("chord_pressed", 32'(pressed), 32'h0);
        applyStimulus(16'h0001, 5);
        checkOutput("chord_partial", 32'(chord), 32'h1);
        checkOutput("chord_partial_pulses", 32'(pulse_total - snap), 32'h0);
        applyStimulus(16'h0000, 5);
        checkOutput("chord_cleared", 32'(chord), 32'h0);
        checkOutput("chord_no_pulse", 32'(pulse_total - snap), 32'h0);
        applyStimulus(16'h0001, 5);
        checkOutput("after_chord_pulses", 32'(pulse_total - snap), 32'h1);
        checkOutput("after_chord_value", 32'(last_res), 32'h0000_0001);
        applyStimulus(16'h0000, 5);

        $display("[TB] reset during pending press");
        snap = pulse_total;
        keys = 16'h0040;
        repeat (36) @(negedge CLK);
        keys  = 16'h0000;
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        checkOutput("midreset_res", 32'(res), 32'h0);
        checkOutput("midreset_pressed", 32'(pressed), 32'h0);
        checkOutput("midreset_h", 32'(h), 32'h0000_000e);
        applyStimulus(16'h0000, 3);
        checkOutput("midreset_no_pulse", 32'(pulse_total - snap), 32'h0);
        applyStimulus(16'h0040, 5);
        checkOutput("postreset_pulses", 32'(pulse_total - snap), 32'h1);
        checkOutput("postreset_value", 32'(last_res), 32'h0000_0040);
        applyStimulus(16'h0000, 5);

        $display("[TB] long hold");
        snap = pulse_total;
        applyStimulus(16'h8000, 20);
        checkOutput("long_pulses", 32'(pulse_total - snap), 32'h1);
        checkOutput("long_value", 32'(last_res), 32'h0000_8000);
        checkOutput("long_pressed", 32'(pressed), 32'h1);
        applyStimulus(16'h0000, 5);
        checkOutput("long_release", 32'(pressed), 32'h0);
        checkOutput("long_release_pulses", 32'(pulse_total - snap), 32'h1);
        applyStimulus(16'h8000, 5);
        checkOutput("repress_pulses", 32'(pulse_total - snap), 32'h2);
        checkOutput("repress_value", 32'(last_res), 32'h0000_8000);
        applyStimulus(16'h0000, 5);

        checkOutput("pulse_width", 32'(wide_total), 32'h0);
        checkOutput("pulse_onehot", 32'(bad_onehot), 32'h0);
        checkOutput("res_in_chord", 32'(res_in_chord), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scan.md
Name: keypad_matrix_scan

Overview:
- Upstream stage of the calculator input path: drives the 4x4 keypad rows H1..H4, samples the columns V1..V4, synchronises and debounces them, and emits a one-cycle one-hot 16-bit key code.
- The key encoder consumes that code and turns it into calculator commands.
- Rejects multi-key chords: a chord emits nothing until every key has been released.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven (dwell). Must be >= 4.
- DEBOUNCE_CNT, 4: consecutive frame-to-frame equal comparisons required before a frame is accepted. Range 1..15.

Ports:
- CLK  in  1  system clock; all state on posedge.
- RESET  in  1  synchronous, active-high reset.
- V1, V2, V3, V4  in  1 each  column inputs, asynchronous, pulled up; 0 = key pressed on the driven row.
- H1, H2, H3, H4  out  1 each  row drives, active-low, exactly one low at any time.
- res  out  16  one-hot key pulse; bit index = row*4 + col (H1/V1 = bit 0, H4/V4 = bit 15); 16'h0000 when idle.
- pressed  out  1  level, high while the accepted single key is held.
- chord  out  1  level, high while state is S_BLOCK.

Behaviour:
- Reset (RESET high at posedge):
  - {H4,H3,H2,H1} = 4'b1110; row = 0; dwell = 0.
  - Sync flops and raw/prev frame = 0; stable counter = 0; debounced frame = 0.
  - State = S_IDLE; res = 0, pressed = 0, chord = 0.
  - Reset mid-scan or mid-press aborts everything; no pulse is emitted on the cycle after reset.
- Synchroniser: V1..V4 pass through two flops, then are inverted to active-high. Sampled bit col = ~V(col+1) after 2 flops.
- Scan:
  - dwell counts 0..SCAN_DIV-1.
  - At dwell == SCAN_DIV-1, the synced 4 column bits are written into raw[row*4 +: 4], row advances mod 4 and the H drive rotates in the same edge; dwell wraps to 0.
  - Sampling at the final dwell cycle guarantees at least 3 settled cycles through the synchroniser.
- Frame end:
  - The capture of row 3 sets frame_done, a registered pulse one cycle later.
  - On frame_done, raw (16 bits) is compared with prev:
    - Equal: stable = min(stable+1, DEBOUNCE_CNT).
    - Not equal: stable = 0 and prev <= raw.
  - When stable reaches DEBOUNCE_CNT, debounced <= prev; this update fires once per reach and is re-armed only by a mismatch.
  - A key must therefore be present in DEBOUNCE_CNT+1 consecutive frames to be accepted.
- FSM, evaluated on each debounced update (deb = new debounced value):
  - S_IDLE: deb == 0 stays. deb has exactly one bit set -> res = deb for exactly one cycle (the cycle after the update), pressed = 1, go to S_PRESS. deb has >= 2 bits set -> go to S_BLOCK, chord = 1, no pulse.
  - S_PRESS: deb == 0 -> S_IDLE, pressed = 0. deb equal to the held key -> stay. Any other non-zero deb -> S_BLOCK, pressed = 0, chord = 1.
  - S_BLOCK: deb == 0 -> S_IDLE, chord = 0. Otherwise stay. A single key remaining after a chord is never emitted until a full release.
- res is 16'h0000 on every cycle except the single pulse cycle, and never has more than one bit set.
- Bounce shorter than one frame only resets stable; no output effect.
- Row rotation is free-running and independent of FSM state.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=2, frame = 16 cycles):
- Reset, then idle columns (all 1) for 10 frames -> H cycles 1110,1101,1011,0111 every 4 clocks; res = 0, pressed = 0, chord = 0 throughout.
- Hold key row2/col1 (V2 low while H3 low) for 4 frames -> exactly one res = 16'h0200 pulse, 1 cycle wide, within 3 frames + 3 cycles of the first sampled frame; pressed high until release debounced.
- Same key toggled every 6 cycles for 5 frames, then held steady -> no pulse during bounce; single 16'h0200 pulse after 3 stable frames.
- Hold H1/V1 and H4/V4 together, release H4/V4 only, then release all -> chord = 1, res never non-zero, return to S_IDLE only after all-zero is accepted; a later press of H1/V1 yields res = 16'h0001.
- Press H2/V3 and assert RESET during the pulse-pending frame -> res stays 0; after reset, pressing and holding again produces a single 16'h0040 pulse.
- Hold key 16'h8000 for 20 frames -> exactly one pulse; pressed stays 1; a second pulse occurs only after a debounced release and a fresh press.
